dac_spi_config_seq: RTL
=======================

Name: dac_spi_config_seq

Overview:
SPI configuration sequencer for the AD9116 DAC pod. After reset it pulses dac_reset_pinmd, then writes three 16-bit register frames: a format register, I-gain from dac_fsadj[7:0] and Q-gain from dac_fsadj[15:8]. It then idles and re-runs the write list whenever dac_fsadj changes or software requests it. Sits between the PS GPIO (dac_fsadj) and the DAC SPI pins, alongside the DDS datapath inside syzygy_dac_top.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
RESET_CYCLES, 16, clk cycles dac_reset_pinmd held high
WAIT_CYCLES, 64, clk cycles after reset release before the first frame
GAP_CYCLES, 4, clk cycles cs_n held high between frames (>=1)
FMT_ADDR, 5'h02, format register address
FMT_DATA, 8'h00, format register data
IGAIN_ADDR, 5'h03, I-gain register address
QGAIN_ADDR, 5'h06, Q-gain register address

Ports:
clk  in  1  system clock
reset_async  in  1  asynchronous reset, active-high
dac_fsadj  in  16  gain settings, [7:0] I and [15:8] Q; quasi-static, clk domain
reconfig  in  1  single-cycle pulse requesting a full rewrite
dac_reset_pinmd  out  1  DAC reset pin
dac_sclk  out  1  SPI clock
dac_sdio_o  out  1  SPI data out
dac_sdio_oe  out  1  SDIO output enable (write-only; top level builds the tristate)
dac_cs_n  out  1  SPI chip select
busy  out  1  sequence in progress
config_done  out  1  at least one full sequence has completed since reset

Behaviour:
- Reset values: dac_reset_pinmd=1, dac_cs_n=1, dac_sclk=0, dac_sdio_o=0, dac_sdio_oe=0, busy=1, config_done=0, state=RST_HOLD, all counters 0.
- Assertion of reset_async at any time, including mid-frame, forces the reset values immediately (cs_n high asynchronously). The sequence restarts from RST_HOLD on release.
- Frame format, 16 bits, MSB first: {R/W=0, N=2'b00, addr[4:0], data[7:0]}.
  - Frame 0 = {FMT_ADDR, FMT_DATA}
  - Frame 1 = {IGAIN_ADDR, snap[7:0]}
  - Frame 2 = {QGAIN_ADDR, snap[15:8]}
- FSM:
  - RST_HOLD: pinmd=1 for RESET_CYCLES clks -> RST_WAIT.
  - RST_WAIT: pinmd=0 for WAIT_CYCLES clks -> LOAD with idx=0. snap<=dac_fsadj on this exit.
  - LOAD (1 clk): shreg<=frame[idx]; cs_n<=0; oe<=1; sdio_o<=frame[idx][15]; sclk=0 -> SHIFT.
  - SHIFT: sclk toggles every CLK_DIV clks, starting low, for 32 half-periods (32*CLK_DIV clks). Each falling edge shifts shreg left and updates sdio_o, so data is stable at each rising edge. After the 16th falling edge -> GAP with cs_n=1, oe=0, sdio_o=0, sclk=0.
  - GAP: GAP_CYCLES clks. If idx<2: idx++ and go to LOAD. Else go to IDLE.
  - IDLE: busy=0, config_done=1 (sticky until reset).
    - If pending=1 or dac_fsadj!=snap: snap<=dac_fsadj, pending<=0, idx=0, busy=1 -> LOAD.
    - Otherwise remain in IDLE.
- pending: set by reconfig in any state other than IDLE; in IDLE, reconfig starts the sequence directly. A reconfig and an fsadj change in the same cycle cause exactly one sequence.
- A dac_fsadj change mid-sequence does not alter frames in flight (snap is frozen). The difference is detected in IDLE and triggers exactly one further sequence.
- Timing per frame: 1 + 32*CLK_DIV + GAP_CYCLES clks. Defaults: 133 clks per frame, 399 per sequence. From reset release, config_done rises at clk 16+64+399 = 479.
- busy is high in every state except IDLE.

Test Plan:
- Defaults, dac_fsadj=16'h1234, release reset -> pinmd high 16 clks; captured frames on sclk rising edges = 16'h0200, 16'h0334, 16'h0612; config_done=1 at clk 479; cs_n high >=4 clks between frames.
- In IDLE, change dac_fsadj to 16'hABCD -> one sequence with frames 0200, 03CD, 06AB; busy high for 399 clks; no reset pulse.
- reconfig pulse during frame 1 of the initial sequence -> initial sequence completes unaltered, then exactly one more identical 3-frame sequence; no third sequence.
- dac_fsadj changed during frame 2 -> in-flight Q frame carries the old value; the following sequence carries the new value.
- Assert reset_async mid-SHIFT -> cs_n=1, sclk=0, oe=0, pinmd=1 in the same cycle; full restart including the reset pulse; config_done cleared.
- CLK_DIV=1, GAP_CYCLES=1 -> sclk period 2 clks; frame length 34 clks; frames still bit-exact.

Source files
------------

// File: rtl/dac_spi_config_seq.sv
// -----------------------------------------------------------------------------
// dac_spi_config_seq
//
// SPI configuration sequencer for the AD9116 DAC pod. After reset it pulses
// the DAC reset pin, waits for the part to settle, then writes three 16-bit
// register frames: format, I-gain (dac_fsadj[7:0]) and Q-gain
// (dac_fsadj[15:8]). It then idles and replays the write list when the gain
// word changes or a rewrite is requested.
//
// Ports:
//   clk              system clock
//   reset_async      asynchronous reset, active-high
//   dac_fsadj[15:0]  gain settings, [7:0] I, [15:8] Q (quasi-static)
//   reconfig         single-cycle pulse requesting a full rewrite
//   dac_reset_pinmd  DAC reset pin
//   dac_sclk         SPI clock (idles low, data sampled by DAC on rising edge)
//   dac_sdio_o       SPI data out, MSB first
//   dac_sdio_oe      SDIO output enable (tristate built at top level)
//   dac_cs_n         SPI chip select, active-low
//   busy             sequence in progress (every state except IDLE)
//   config_done      sticky: a full sequence has completed since reset
// -----------------------------------------------------------------------------
module dac_spi_config_seq #(
    parameter int          CLK_DIV      = 4,
    parameter int          RESET_CYCLES = 16,
    parameter int          WAIT_CYCLES  = 64,
    parameter int          GAP_CYCLES   = 4,
    parameter logic [4:0]  FMT_ADDR     = 5'h02,
    parameter logic [7:0]  FMT_DATA     = 8'h00,
    parameter logic [4:0]  IGAIN_ADDR   = 5'h03,
    parameter logic [4:0]  QGAIN_ADDR   = 5'h06
) (
    input  logic        clk,
    input  logic        reset_async,
    input  logic [15:0] dac_fsadj,
    input  logic        reconfig,
    output logic        dac_reset_pinmd,
    output logic        dac_sclk,
    output logic        dac_sdio_o,
    output logic        dac_sdio_oe,
    output logic        dac_cs_n,
    output logic        busy,
    output logic        config_done
);

    typedef enum logic [2:0] {
        RST_HOLD,
        RST_WAIT,
        LOAD,
        SHIFT,
        GAP,
        IDLE
    } state_t;

    // One shared down-timer serves the reset hold, reset wait, SCLK
    // half-period and inter-frame gap; 16 bits covers any sane setting.
    localparam logic [15:0] RESET_LAST = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(WAIT_CYCLES - 1);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [4:0]  half_cnt, half_cnt_d;   // SCLK half-periods elapsed in frame
    logic [1:0]  idx, idx_d;             // frame index within the write list
    logic [15:0] snap, snap_d;           // gain word frozen for the sequence
    logic [14:0] shreg, shreg_d;         // bits still to be sent after sdio_o
    logic        pending, pending_d;
    logic        pinmd_d, sclk_d, sdio_d, oe_d, cs_n_d, done_d;
    logic [15:0] frame_cur;

    // Frame word: {R/W=0, N=2'b00, addr[4:0], data[7:0]}.
    always_comb begin
        case (idx)
            2'd0:    frame_cur = {3'b000, FMT_ADDR,   FMT_DATA};
            2'd1:    frame_cur = {3'b000, IGAIN_ADDR, snap[7:0]};
            default: frame_cur = {3'b000, QGAIN_ADDR, snap[15:8]};
        endcase
    end

    assign busy = (state != IDLE);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        half_cnt_d = half_cnt;
        idx_d      = idx;
        snap_d     = snap;
        shreg_d    = shreg;
        pending_d  = pending;
        pinmd_d    = dac_reset_pinmd;
        sclk_d     = dac_sclk;
        sdio_d     = dac_sdio_o;
        oe_d       = dac_sdio_oe;
        cs_n_d     = dac_cs_n;
        done_d     = config_done;

        case (state)
            RST_HOLD: begin
                pinmd_d = 1'b1;
                if (cnt == RESET_LAST) begin
                    cnt_d   = '0;
                    pinmd_d = 1'b0;
                    state_d = RST_WAIT;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end

            RST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    snap_d  = dac_fsadj;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end

            LOAD: begin
                shreg_d    = frame_cur[14:0];
                sdio_d     = frame_cur[15];
                cs_n_d     = 1'b0;
                oe_d       = 1'b1;
                sclk_d     = 1'b0;
                cnt_d      = '0;
                half_cnt_d = '0;
                state_d    = SHIFT;
            end

            SHIFT: begin
                if (cnt == DIV_LAST) begin
                    cnt_d      = '0;
                    sclk_d     = ~dac_sclk;
                    half_cnt_d = half_cnt + 5'd1;
                    // Data only moves on the falling edge so it is stable
                    // across the following rising edge.
                    if (dac_sclk) begin
                        if (half_cnt == 5'd31) begin
                            cs_n_d  = 1'b1;
                            oe_d    = 1'b0;
                            sdio_d  = 1'b0;
                            sclk_d  = 1'b0;
                            state_d = GAP;
                        end else begin
                            sdio_d  = shreg[14];
                            shreg_d = {shreg[13:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end

            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx != 2'd2) begin
                        idx_d   = idx + 2'd1;
                        state_d = LOAD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end

            IDLE: begin
                // A reconfig and a gain change in the same cycle collapse
                // into one sequence: both are consumed here at once.
                if (pending || reconfig || (dac_fsadj != snap)) begin
                    snap_d    = dac_fsadj;
                    pending_d = 1'b0;
                    idx_d     = 2'd0;
                    state_d   = LOAD;
                end
            end

            default: state_d = RST_HOLD;
        endcase

        // Requests arriving while busy are remembered and replayed from IDLE.
        if ((state != IDLE) && reconfig) begin
            pending_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            state           <= RST_HOLD;
            cnt             <= '0;
            half_cnt        <= '0;
            idx             <= '0;
            snap            <= '0;
            shreg           <= '0;
            pending         <= 1'b0;
            dac_reset_pinmd <= 1'b1;
            dac_sclk        <= 1'b0;
            dac_sdio_o      <= 1'b0;
            dac_sdio_oe     <= 1'b0;
            dac_cs_n        <= 1'b1;
            config_done     <= 1'b0;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            half_cnt        <= half_cnt_d;
            idx             <= idx_d;
            snap            <= snap_d;
            shreg           <= shreg_d;
            pending         <= pending_d;
            dac_reset_pinmd <= pinmd_d;
            dac_sclk        <= sclk_d;
            dac_sdio_o      <= sdio_d;
            dac_sdio_oe     <= oe_d;
            dac_cs_n        <= cs_n_d;
            config_done     <= done_d;
        end
    end

endmodule
